color_frame_analyzer: RTL and testbench
=======================================

Name: color_frame_analyzer

Overview:
- Downstream consumer of the camera capture stage's frame RAM.
- On request, freezes capture and reads one stored frame of RGB565 byte pairs sequentially from the RAM read port.
- Classifies each pixel as red/green/blue/other, counts each class, and reports the dominant colour with per-class counts.
- Result feeds the colour-recognition control logic.

Parameters:
- ADDR_W, 15, RAM address width; matches the capture stage's write address.
- FRAME_BYTES, 20000, bytes per stored frame; must be even and ≤ 2^ADDR_W.
- COUNT_W, 15, per-class pixel counter width; counters saturate at all-ones.
- MIN_LEVEL, 8, minimum 5-bit channel value for a pixel to be classified.
- MARGIN, 4, amount by which the winning channel must exceed both others (5-bit scale).
- MIN_PIXELS, 100, dominant-class count must be ≥ this, else result is NONE.

Ports:
- i_Clk, input, 1, system clock.
- i_Reset, input, 1, reset; synchronous, active-high.
- i_Start, input, 1, single-cycle analysis request; honoured only in IDLE.
- o_CaptureEnable, output, 1, drives the capture stage's camera-read enable; 0 while reading RAM.
- o_RAM_Read_Adress, output, ADDR_W, RAM read address.
- i_RAM_Data, input, 8, RAM read data; valid exactly 1 cycle after the address is presented.
- o_Busy, output, 1, high from the cycle after start until o_Done.
- o_Done, output, 1, one-cycle pulse when the result is valid.
- o_Color, output, 2, 0 = NONE, 1 = RED, 2 = GREEN, 3 = BLUE; held until the next accepted start.
- o_Count_R / o_Count_G / o_Count_B, output, COUNT_W each, final per-class counts; held until the next accepted start.

Behaviour:
- Reset values: all outputs 0 except o_CaptureEnable = 1. State = IDLE, address = 0, counters cleared.
- States: IDLE → RUN → DRAIN → DONE → IDLE.
- IDLE: o_CaptureEnable = 1. If i_Start = 1 at cycle 0, clear counters, set o_Busy, drop o_CaptureEnable, go to RUN. i_Start while not in IDLE is ignored.
- RUN: address 0 is presented at cycle 1. The address increments by 1 every cycle through FRAME_BYTES-1, which is presented at cycle FRAME_BYTES. Then go to DRAIN. No wrap; the address returns to 0 in DONE.
- Byte order: even address = high byte {R[4:0], G[5:3]}; odd address = low byte {G[2:0], B[4:0]}.
  - The high byte is latched when it arrives.
  - The pixel is formed when the low byte arrives.
  - A delayed valid flag and a phase flag track the 1-cycle RAM latency.
- Classification, registered one cycle after pixel assembly:
  - R5 = R, G5 = G6 >> 1, B5 = B.
  - RED if R5 ≥ MIN_LEVEL and R5 ≥ G5 + MARGIN and R5 ≥ B5 + MARGIN. GREEN and BLUE are defined the same way on their own channel.
  - Otherwise OTHER, which is not counted.
  - Comparisons use 6-bit sums so there is no overflow.
- Counters saturate at 2^COUNT_W - 1.
- DRAIN: lasts 2 cycles so the last byte and the final counter update complete. Then DONE.
- DONE, cycle FRAME_BYTES+3 after start:
  - Dominant = largest count; tie priority RED > GREEN > BLUE.
  - o_Color = dominant if its count ≥ MIN_PIXELS, else NONE.
  - Register the counts, pulse o_Done, clear o_Busy, set o_CaptureEnable = 1, return to IDLE.
- i_Start coincident with the DONE cycle is ignored.
- Reset mid-operation: abort immediately and return to reset values. Previous results are lost (outputs become 0). o_CaptureEnable returns to 1.

Optional Feature:
- Macro: COLOR_ANALYZER_ROI_EN.
- With the macro defined:
  - Added parameters: IMG_WIDTH (default 100), ROI_X0, ROI_X1, ROI_Y0, ROI_Y1.
  - Column/row pixel counters are maintained. Column wraps at IMG_WIDTH-1 and increments the row.
  - Only pixels with X0 ≤ col ≤ X1 and Y0 ≤ row ≤ Y1 (inclusive) are counted.
  - Timing is unchanged.
- Without the macro: every pixel is counted, and no column/row logic exists.

Decomposition:
- Shared package color_pkg:
  - Colour code constants COLOR_NONE / RED / GREEN / BLUE.
  - Analyzer state encoding.
  - RGB565 field bit positions.
- One natural sub-module: rgb565_classifier.
  - Inputs: 16-bit pixel and valid.
  - Outputs: registered one-hot {is_r, is_g, is_b} and valid, MIN_LEVEL and MARGIN as parameters.
  - The top level holds the FSM, address generation, byte assembly, counters and result logic.

Test Plan:
- FRAME_BYTES = 8, MIN_PIXELS = 2, RAM = F8 00 F8 00 F8 00 07 E0; start at cycle 0 → o_Done at cycle 11, Color = 1, R = 3, G = 1, B = 0.
- Frame of 0x001F ×2 and 0xFFFF ×2 → Color = 3, B = 2. White counts as other (R = G = B = 0 beyond blue).
- 0xF800 ×2 and 0x07E0 ×2 → tie → Color = 1. Same frame with MIN_PIXELS = 3 → Color = 0.
- i_Start pulsed at cycles 0 and 4 → only one o_Done at cycle 11. Address sequence is exactly 0..7 at cycles 1..8. o_CaptureEnable = 0 for cycles 1..10.
- i_Reset asserted at cycle 5 → next cycle: IDLE, o_Busy = 0, o_CaptureEnable = 1, counts 0, no o_Done. A new start then runs a full, correct pass.
- With COLOR_ANALYZER_ROI_EN, IMG_WIDTH = 2, ROI col 1 / row 1, 4 red pixels → R = 1.

Source files
------------

// File: rtl/color_pkg.sv
// color_pkg: shared colour codes, analyzer state encoding and RGB565 field positions.
package color_pkg;
  localparam logic [1:0] COLOR_NONE  = 2'd0;
  localparam logic [1:0] COLOR_RED   = 2'd1;
  localparam logic [1:0] COLOR_GREEN = 2'd2;
  localparam logic [1:0] COLOR_BLUE  = 2'd3;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  localparam int R_HI = 15;
  localparam int R_LO = 11;
  localparam int G_HI = 10;
  localparam int G_LO = 5;
  localparam int B_HI = 4;
  localparam int B_LO = 0;
endpackage

// File: rtl/rgb565_classifier.sv
// rgb565_classifier: registered one-hot red/green/blue decision for one RGB565 pixel.
module rgb565_classifier import color_pkg::*; #(
  parameter int MIN_LEVEL = 8,
  parameter int MARGIN    = 4
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic [15:0] i_Pixel,
  input  logic        i_Valid,
  output logic        o_Is_R,
  output logic        o_Is_G,
  output logic        o_Is_B,
  output logic        o_Valid
);
  localparam logic [5:0] LVL = 6'(MIN_LEVEL);
  localparam logic [5:0] MRG = 6'(MARGIN);
  logic [5:0] w_r, w_g, w_b;
  // Green drops its LSB so all channels share the 5-bit scale; 6-bit sums avoid overflow.
  assign w_r = {1'b0, i_Pixel[R_HI:R_LO]};
  assign w_g = {1'b0, i_Pixel[G_HI:G_LO+1]};
  assign w_b = {1'b0, i_Pixel[B_HI:B_LO]};
  function automatic logic wins(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
    return (a >= LVL) && (a >= b + MRG) && (a >= c + MRG);
  endfunction
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      o_Valid <= 1'b0;
      o_Is_R  <= 1'b0;
      o_Is_G  <= 1'b0;
      o_Is_B  <= 1'b0;
    end else begin
      o_Valid <= i_Valid;
      o_Is_R  <= i_Valid && wins(w_r, w_g, w_b);
      o_Is_G  <= i_Valid && wins(w_g, w_r, w_b);
      o_Is_B  <= i_Valid && wins(w_b, w_r, w_g);
    end
  end
endmodule

// File: rtl/color_frame_analyzer.sv
// color_frame_analyzer: reads one stored RGB565 frame, counts red/green/blue pixels, reports the dominant colour.
// Optional region-of-interest filtering when COLOR_ANALYZER_ROI_EN is defined.
module color_frame_analyzer import color_pkg::*; #(
  parameter int ADDR_W      = 15,
  parameter int FRAME_BYTES = 20000,
  parameter int COUNT_W     = 15,
  parameter int MIN_LEVEL   = 8,
  parameter int MARGIN      = 4,
  parameter int MIN_PIXELS  = 100
`ifdef COLOR_ANALYZER_ROI_EN
  ,
  parameter int IMG_WIDTH   = 100,
  parameter int ROI_X0      = 0,
  parameter int ROI_X1      = IMG_WIDTH - 1,
  parameter int ROI_Y0      = 0,
  parameter int ROI_Y1      = 65535
`endif
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  input  logic               i_Start,
  output logic               o_CaptureEnable,
  output logic [ADDR_W-1:0]  o_RAM_Read_Adress,
  input  logic [7:0]         i_RAM_Data,
  output logic               o_Busy,
  output logic               o_Done,
  output logic [1:0]         o_Color,
  output logic [COUNT_W-1:0] o_Count_R,
  output logic [COUNT_W-1:0] o_Count_G,
  output logic [COUNT_W-1:0] o_Count_B
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_BYTES - 1);
  localparam logic [COUNT_W-1:0] MIN_CNT = COUNT_W'(MIN_PIXELS);
  state_t r_state;
  logic [ADDR_W-1:0] r_addr;
  logic r_drain, r_rd_valid, r_rd_phase, r_busy, r_done, r_cap;
  logic [7:0] r_hi;
  logic [1:0] r_color;
  logic [COUNT_W-1:0] r_cnt_r, r_cnt_g, r_cnt_b, r_out_r, r_out_g, r_out_b;
  logic w_pix_valid, w_cls_valid, w_v, w_is_r, w_is_g, w_is_b, w_start;
  logic [15:0] w_pix;
  logic [COUNT_W-1:0] w_nxt_r, w_nxt_g, w_nxt_b, w_max;
  logic [1:0] w_code;
  assign w_start = (r_state == S_IDLE) && i_Start;
  assign w_pix = {r_hi, i_RAM_Data};
  // Read data lags the address by one cycle; odd-address bytes complete a pixel.
  assign w_pix_valid = r_rd_valid && r_rd_phase;
`ifdef COLOR_ANALYZER_ROI_EN
  logic [15:0] r_col, r_row;
  always_ff @(posedge i_Clk) begin
    if (i_Reset || w_start) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_pix_valid) begin
      r_col <= (r_col == 16'(IMG_WIDTH - 1)) ? '0 : r_col + 1'b1;
      r_row <= (r_col == 16'(IMG_WIDTH - 1)) ? r_row + 1'b1 : r_row;
    end
  end
  assign w_cls_valid = w_pix_valid && (r_col >= 16'(ROI_X0)) && (r_col <= 16'(ROI_X1))
                       && (r_row >= 16'(ROI_Y0)) && (r_row <= 16'(ROI_Y1));
`else
  assign w_cls_valid = w_pix_valid;
`endif
  rgb565_classifier #(.MIN_LEVEL(MIN_LEVEL), .MARGIN(MARGIN)) u_cls (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_Pixel (w_pix),
    .i_Valid (w_cls_valid),
    .o_Is_R  (w_is_r),
    .o_Is_G  (w_is_g),
    .o_Is_B  (w_is_b),
    .o_Valid (w_v)
  );
  assign w_nxt_r = (w_v && w_is_r && !(&r_cnt_r)) ? r_cnt_r + 1'b1 : r_cnt_r;
  assign w_nxt_g = (w_v && w_is_g && !(&r_cnt_g)) ? r_cnt_g + 1'b1 : r_cnt_g;
  assign w_nxt_b = (w_v && w_is_b && !(&r_cnt_b)) ? r_cnt_b + 1'b1 : r_cnt_b;
  // Result uses the next-count values so the final pixel's update lands in the same edge.
  always_comb begin
    w_code = (w_nxt_r >= w_nxt_g && w_nxt_r >= w_nxt_b) ? COLOR_RED :
             (w_nxt_g >= w_nxt_b) ? COLOR_GREEN : COLOR_BLUE;
    w_max  = (w_code == COLOR_RED) ? w_nxt_r : (w_code == COLOR_GREEN) ? w_nxt_g : w_nxt_b;
  end
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_drain    <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_phase <= 1'b0;
      r_hi       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cap      <= 1'b1;
      r_color    <= COLOR_NONE;
      r_cnt_r    <= '0;
      r_cnt_g    <= '0;
      r_cnt_b    <= '0;
      r_out_r    <= '0;
      r_out_g    <= '0;
      r_out_b    <= '0;
    end else begin
      r_rd_valid <= (r_state == S_RUN);
      r_rd_phase <= r_addr[0];
      if (r_rd_valid && !r_rd_phase) r_hi <= i_RAM_Data;
      r_done  <= 1'b0;
      r_cnt_r <= w_start ? '0 : w_nxt_r;
      r_cnt_g <= w_start ? '0 : w_nxt_g;
      r_cnt_b <= w_start ? '0 : w_nxt_b;
      case (r_state)
        S_IDLE: if (i_Start) begin
          r_state <= S_RUN;
          r_busy  <= 1'b1;
          r_cap   <= 1'b0;
        end
        S_RUN: if (r_addr == LAST_ADDR) begin
          r_state <= S_DRAIN;
          r_drain <= 1'b0;
        end else begin
          r_addr <= r_addr + 1'b1;
        end
        S_DRAIN: begin
          r_drain <= 1'b1;
          if (r_drain) begin
            r_state <= S_DONE;
            r_addr  <= '0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_cap   <= 1'b1;
            r_color <= (w_max >= MIN_CNT) ? w_code : COLOR_NONE;
            r_out_r <= w_nxt_r;
            r_out_g <= w_nxt_g;
            r_out_b <= w_nxt_b;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign o_CaptureEnable   = r_cap;
  assign o_RAM_Read_Adress = r_addr;
  assign o_Busy            = r_busy;
  assign o_Done            = r_done;
  assign o_Color           = r_color;
  assign o_Count_R         = r_out_r;
  assign o_Count_G         = r_out_g;
  assign o_Count_B         = r_out_b;
endmodule

// File: tb/tb_color_frame_analyzer.sv
// tb_color_frame_analyzer: directed checks of frame analysis timing, classification, ties and reset abort.
module tb_color_frame_analyzer;
  logic clk = 1'b0;
  logic i_reset, i_start;
  logic cap0, busy0, done0, cap1, busy1, done1;
  logic [3:0] addr0, addr1;
  logic [7:0] q0, q1;
  logic [1:0] color0, color1;
  logic [14:0] cr0, cg0, cb0, cr1, cg1, cb1;
  logic [7:0] mem [16];
  int n_checks = 0;
  int n_fail = 0;
  int dcyc, dcnt;
  bit addr_ok, ctl_ok;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    q0 <= mem[addr0];
    q1 <= mem[addr1];
  end

  color_frame_analyzer #(.ADDR_W(4), .FRAME_BYTES(8), .MIN_PIXELS(2)) u0 (
    .i_Clk(clk), .i_Reset(i_reset), .i_Start(i_start), .o_CaptureEnable(cap0),
    .o_RAM_Read_Adress(addr0), .i_RAM_Data(q0), .o_Busy(busy0), .o_Done(done0),
    .o_Color(color0), .o_Count_R(cr0), .o_Count_G(cg0), .o_Count_B(cb0)
  );

  color_frame_analyzer #(.ADDR_W(4), .FRAME_BYTES(8), .MIN_PIXELS(3)) u1 (
    .i_Clk(clk), .i_Reset(i_reset), .i_Start(i_start), .o_CaptureEnable(cap1),
    .o_RAM_Read_Adress(addr1), .i_RAM_Data(q1), .o_Busy(busy1), .o_Done(done1),
    .o_Color(color1), .o_Count_R(cr1), .o_Count_G(cg1), .o_Count_B(cb1)
  );

`ifdef COLOR_ANALYZER_ROI_EN
  logic cap2, busy2, done2;
  logic [3:0] addr2;
  logic [7:0] q2;
  logic [1:0] color2;
  logic [14:0] cr2, cg2, cb2;
  always_ff @(posedge clk) q2 <= mem[addr2];
  color_frame_analyzer #(.ADDR_W(4), .FRAME_BYTES(8), .MIN_PIXELS(1), .IMG_WIDTH(2),
                         .ROI_X0(1), .ROI_X1(1), .ROI_Y0(1), .ROI_Y1(1)) u2 (
    .i_Clk(clk), .i_Reset(i_reset), .i_Start(i_start), .o_CaptureEnable(cap2),
    .o_RAM_Read_Adress(addr2), .i_RAM_Data(q2), .o_Busy(busy2), .o_Done(done2),
    .o_Color(color2), .o_Count_R(cr2), .o_Count_G(cg2), .o_Count_B(cb2)
  );
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic load(input logic [63:0] bytes);
    for (int i = 0; i < 8; i++) mem[i] = bytes[63-8*i -: 8];
  endtask

  // Start at cycle 0, observe cycles 1..20 at the falling edge.
  task automatic run(input bit pulse4);
    @(negedge clk);
    i_start = 1'b1;
    dcyc = -1;
    dcnt = 0;
    addr_ok = 1'b1;
    ctl_ok = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      i_start = pulse4 && (k == 4);
      if (k <= 8 && addr0 !== 4'(k - 1)) addr_ok = 1'b0;
      if (k <= 10 && (cap0 !== 1'b0 || busy0 !== 1'b1)) ctl_ok = 1'b0;
      if (k == 11 && (cap0 !== 1'b1 || busy0 !== 1'b0)) ctl_ok = 1'b0;
      if (done0 === 1'b1) begin
        dcnt++;
        if (dcyc < 0) dcyc = k;
      end
    end
  endtask

  task automatic check_result(input string tag, input int col, input int r, input int g, input int b, input int col1);
    check({tag, "_done_cycle"}, dcyc, 11);
    check({tag, "_done_count"}, dcnt, 1);
    check({tag, "_color"}, 32'(color0), col);
    check({tag, "_count_r"}, 32'(cr0), r);
    check({tag, "_count_g"}, 32'(cg0), g);
    check({tag, "_count_b"}, 32'(cb0), b);
    check({tag, "_color_minpix3"}, 32'(color1), col1);
  endtask

  initial begin
    i_reset = 1'b1;
    i_start = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    check("rst_capture", 32'(cap0), 1);
    check("rst_busy", 32'(busy0), 0);
    check("rst_done", 32'(done0), 0);
    check("rst_color", 32'(color0), 0);
    check("rst_addr", 32'(addr0), 0);
    check("rst_counts", 32'(cr0) + 32'(cg0) + 32'(cb0), 0);

    // Three red, one green, second start at cycle 4 must be ignored.
    load(64'hF800_F800_F800_07E0);
    run(1'b1);
    check("a_addr_seq", 32'(addr_ok), 1);
    check("a_ctl_timing", 32'(ctl_ok), 1);
    check_result("a", 1, 3, 1, 0, 1);

    // Two blue, two white (white is unclassified).
    load(64'h001F_001F_FFFF_FFFF);
    run(1'b0);
    check_result("b", 3, 0, 0, 2, 0);

    // Red/green tie resolves to red; below MIN_PIXELS=3 gives none.
    load(64'hF800_F800_07E0_07E0);
    run(1'b0);
    check_result("c", 1, 2, 2, 0, 0);

    // Reset mid-run at cycle 5.
    @(negedge clk);
    i_start = 1'b1;
    repeat (5) begin
      @(negedge clk);
      i_start = 1'b0;
    end
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    check("abort_busy", 32'(busy0), 0);
    check("abort_capture", 32'(cap0), 1);
    check("abort_color", 32'(color0), 0);
    check("abort_counts", 32'(cr0) + 32'(cg0) + 32'(cb0), 0);
    check("abort_addr", 32'(addr0), 0);
    dcnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done0 === 1'b1) dcnt++;
    end
    check("abort_no_done", dcnt, 0);

    // Fresh pass after abort.
    load(64'h07E0_07E0_07E0_001F);
    run(1'b0);
    check("d_addr_seq", 32'(addr_ok), 1);
    check("d_ctl_timing", 32'(ctl_ok), 1);
    check_result("d", 2, 0, 3, 1, 2);

`ifdef COLOR_ANALYZER_ROI_EN
    load(64'hF800_F800_F800_F800);
    run(1'b0);
    check("roi_count_r", 32'(cr2), 1);
    check("roi_color", 32'(color2), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
